prime_pair_fetch: RTL

PRIME_PAIR_FETCH -- requirements
Module: prime_pair_fetch

---
 rtl/prime_pair_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prime_pair_fetch.sv
// rtl/prime_pair_fetch.sv - fetches two distinct primes from a registered ROM and forms their product
module prime_pair_fetch #(
    parameter int DEPTH  = 6801,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     seed_p,
    input  logic [ADDR_W-1:0]     seed_q,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_W-1:0]     p,
    output logic [DATA_W-1:0]     q,
    output logic [2*DATA_W-1:0]   n,
    output logic                  err
);

    typedef enum logic [2:0] {IDLE, ADDR_Q, CAP_P, CAP_Q, MUL} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   qidx_q, qidx_d;
    logic [DATA_W-1:0]   cap_p_q, cap_p_d;
    logic [DATA_W-1:0]   cap_q_q, cap_q_d;
    logic [DATA_W-1:0]   p_q, p_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [2*DATA_W-1:0] n_q, n_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;

    logic [ADDR_W-1:0]   idx_p, idx_q_raw, idx_q;

    // Seeds are below 2*DEPTH by construction, so a single conditional subtract normalises them.
    always_comb begin
        idx_p     = ({1'b0, seed_p} >= DEPTH_X) ? seed_p - DEPTH_A : seed_p;
        idx_q_raw = ({1'b0, seed_q} >= DEPTH_X) ? seed_q - DEPTH_A : seed_q;
        idx_q     = idx_q_raw;
        if (idx_q_raw == idx_p) begin
            idx_q = (idx_p == LAST_IDX) ? '0 : idx_p + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        qidx_d     = qidx_q;
        cap_p_d    = cap_p_q;
        cap_q_d    = cap_q_q;
        p_d        = p_q;
        q_d        = q_q;
        n_d        = n_q;
        err_d      = err_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    qidx_d     = idx_q;
                    rom_addr_d = idx_p;
                    busy_d     = 1'b1;
                    state_d    = ADDR_Q;
                end
            end
            ADDR_Q: begin
                rom_addr_d = qidx_q;
                state_d    = CAP_P;
            end
            CAP_P: begin
                cap_p_d = rom_data;
                state_d = CAP_Q;
            end
            CAP_Q: begin
                cap_q_d = rom_data;
                state_d = MUL;
            end
            MUL: begin
                // Visible results only change together with the valid pulse.
                p_d     = cap_p_q;
                q_d     = cap_q_q;
                n_d     = {{DATA_W{1'b0}}, cap_p_q} * {{DATA_W{1'b0}}, cap_q_q};
                err_d   = (cap_p_q == '0) || (cap_q_q == '0);
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            qidx_q     <= '0;
            cap_p_q    <= '0;
            cap_q_q    <= '0;
            p_q        <= '0;
            q_q        <= '0;
            n_q        <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            qidx_q     <= qidx_d;
            cap_p_q    <= cap_p_d;
            cap_q_q    <= cap_q_d;
            p_q        <= p_d;
            q_q        <= q_d;
            n_q        <= n_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign p        = p_q;
    assign q        = q_q;
    assign n        = n_q;
    assign err      = err_q;

endmodule
